fir_sample_driver: RTL

FIR_SAMPLE_DRIVER -- requirements
Module: fir_sample_driver

---
 rtl/fir_drv_pkg.sv | 16 +
 rtl/fir_sample_driver_if.sv | 32 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/fir_sample_driver.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fir_drv_pkg.sv
// Shared definitions for the FIR sample driver: controller states and default widths.
package fir_drv_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_OUT_W      = 38;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TMO_CYC    = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/fir_sample_driver_if.sv
// Signal bundle between the sample driver (master), the upstream source,
// the FIR datapath/controller and the downstream result consumer.
interface fir_sample_driver_if
    import fir_drv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_OUT_W
) ();

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] fir_in;
    logic              Input_Valid;
    logic              Output_Valid;
    logic [OUT_W-1:0]  fir_out;
    logic [OUT_W-1:0]  m_data;
    logic              m_valid;
    logic              m_ready;
    logic              timeout_err;

    modport master (
        input  s_data, s_valid, Output_Valid, fir_out, m_ready,
        output s_ready, fir_in, Input_Valid, m_data, m_valid, timeout_err
    );

    modport slave (
        output s_data, s_valid, Output_Valid, fir_out, m_ready,
        input  s_ready, fir_in, Input_Valid, m_data, m_valid, timeout_err
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage carries no reset; only pointers and count define validity,
    // so the array can map onto plain RAM/register cells without reset logic.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fir_sample_driver.sv
// Feeds buffered samples one at a time into a FIR core, waits (with timeout)
// for each result and holds it until the downstream consumer takes it.
module fir_sample_driver
    import fir_drv_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TMO_CYC    = DEF_TMO_CYC
) (
    input  logic                clk,
    input  logic                rst,
    fir_sample_driver_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    state_t            state;
    state_t            state_next;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0] fir_in_q;
    logic [OUT_W-1:0]  m_data_q;
    logic              m_valid_q;
    logic              timeout_q;
    logic [TW-1:0]     wait_cnt;
    logic              input_valid;
    logic              load_fir;
    logic              capture;
    logic              release_res;
    logic              tmo_hit;
    logic              cnt_clr;
    logic              cnt_inc;

    assign bus.s_ready     = (fifo_count < FULL_CNT);
    assign push            = bus.s_valid && bus.s_ready;
    assign bus.fir_in      = fir_in_q;
    assign bus.Input_Valid = input_valid;
    assign bus.m_data      = m_data_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.timeout_err = timeout_q;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.s_data),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every output of this block is defaulted before the case so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        load_fir    = 1'b0;
        input_valid = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        tmo_hit     = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        unique case (state)
            IDLE: begin
                // Head is latched on the way into SEND so fir_in is stable for the whole strobe.
                if (!fifo_empty && !m_valid_q) begin
                    pop        = 1'b1;
                    load_fir   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                input_valid = 1'b1;
                cnt_clr     = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                if (bus.Output_Valid) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end else if (wait_cnt == TMO_LAST) begin
                    tmo_hit    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    release_res = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fir_in_q  <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            timeout_q <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (load_fir)
                fir_in_q <= fifo_head;
            if (capture) begin
                m_data_q  <= bus.fir_out;
                m_valid_q <= 1'b1;
            end else if (release_res) begin
                m_valid_q <= 1'b0;
            end
            if (tmo_hit)
                timeout_q <= 1'b1;
            if (cnt_clr)
                wait_cnt <= '0;
            else if (cnt_inc)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assert property (@(posedge clk) disable iff (rst) fifo_full == (fifo_count == FULL_CNT));

endmodule
